register_uart_bridge: RTL and testbench
=======================================

# register_uart_bridge

Command bridge that sits directly upstream of the memory-mapped register block. Parses a byte stream from the UART receiver into register reads and writes, drives the register block's address, write-data and write-enable inputs, and captures its registered read data. Returns the read result or a write acknowledge to the UART transmitter.

## Interface
- `TIMEOUT_CYCLES`, default 50000: inter-byte timeout in clock cycles; 1 ms at 50 MHz.
- `ipClk` in, 1: system clock. One clock domain; everything is on the rising edge.
- `ipReset` in, 1: asynchronous, active-high reset.
- `ipRxData` in, 8: received byte.
- `ipRxValid` in, 1: one-cycle strobe; `ipRxData` is valid when it is high.
- `opTxData` out, 8: byte to transmit.
- `opTxValid` out, 1: a transmit byte is offered.
- `ipTxReady` in, 1: the transmitter accepts the byte.
- `opAddress` out, 8: register address, to the register block's `ipAddress`.
- `opWrData` out, 32: register write data.
- `opWrEnable` out, 1: one-cycle write strobe.
- `ipRdData` in, 32: register read data; valid one edge after the address is sampled.
- `opError` out, 1: one-cycle pulse on an unknown command or a timeout.

## Operation
- Packet formats:
  - Read: `0x01`, then ADDR.
  - Write: `0x02`, then ADDR, then D0, D1, D2, D3 (LSB first).
- States: IDLE, ADDR, WDATA, WRITE, RD_ADDR, RD_WAIT, RD_CAP, TX.
- IDLE, on a received byte:
  - `0x01` or `0x02`: latch the command and go to ADDR.
  - Any other value: load `0xEE` as a single TX byte, pulse `opError`, go to TX.
- ADDR, on a received byte:
  - Latch it into `opAddress`.
  - Read: go to RD_ADDR. Write: go to WDATA with the byte count at 0.
- WDATA:
  - Each byte shifts into `opWrData[8*n+7:8*n]`, n = 0..3.
  - After the 4th byte, go to WRITE.
- WRITE:
  - `opWrEnable` is high for exactly this one cycle; address and data are stable.
  - Load ack `0xA5` as a single TX byte and go to TX.
- RD_ADDR, RD_WAIT, RD_CAP:
  - The address is held through all three states.
  - RD_CAP latches `ipRdData` into a 32-bit TX shift register, TX count = 4, then goes to TX.
- TX:
  - Offers bytes LSB first.
  - A byte transfers only on a cycle where `opTxValid && ipTxReady`.
  - `opTxData` is stable while `opTxValid` is high and not accepted.
  - After the last byte, `opTxValid` drops and the state returns to IDLE.
- Received bytes are accepted only in IDLE, ADDR and WDATA.
  - In any other state `ipRxValid` is ignored and the byte is dropped. There is no backpressure on RX.
- `opAddress` and `opWrData` hold their last values between transactions.

## Timing
- Reset values: `opAddress`=0, `opWrData`=0, `opWrEnable`=0, `opTxValid`=0, `opTxData`=0, `opError`=0, state IDLE, all counters 0.
- Reset asserted mid-transaction aborts immediately: no write strobe, no TX byte.
- Read latency:
  - The ADDR byte strobe is at edge k; `opAddress` is valid after k.
  - The register block samples the address at k+1, and `ipRdData` is valid after k+1.
  - The bridge captures at k+2 (RD_CAP); `opTxValid` rises after k+3.
- Write:
  - `opWrEnable` rises 1 cycle after the D3 strobe edge and lasts exactly 1 cycle.
  - `opTxValid` with `0xA5` rises the cycle after that.
- Back-to-back packets:
  - A command byte arriving the cycle after TX returns to IDLE is accepted.
  - A byte arriving during the last TX handshake cycle is dropped.
- `opError` is a single-cycle pulse, coincident with the transition out of IDLE (unknown command) or out of ADDR/WDATA (timeout).

## Configuration
- Macro: `REGISTER_UART_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in ADDR and WDATA. It clears on every accepted byte and on entry to either state.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, pulses `opError`, sends no response and issues no write.
  - A byte strobe on the same cycle as the terminal count wins: it is accepted and the timeout does not fire.
- Undefined: no counter is built, and the FSM waits in ADDR or WDATA indefinitely.

## Test plan
- Write: RX `02 03 78 56 34 12` -> `opWrEnable` is one pulse with `opAddress`=0x03 and `opWrData`=0x12345678; TX `A5`.
- Read: RX `01 00`, with the register model returning 0xDEADBEEF for address 0 one edge after sampling -> TX `EF BE AD DE`; no `opWrEnable`.
- TX backpressure: same read with `ipTxReady` low for 5 cycles between bytes -> each `opTxData` value is held, and all 4 bytes are sent once each, in order.
- Unknown command: RX `7F` -> `opError` is one pulse; TX `EE`; a following `01 02` read completes normally.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): RX `02 05 11`, then 16 idle cycles -> `opError` pulse, no write, no TX, state IDLE. With the macro undefined, the same stimulus leaves the FSM in WDATA.
- Reset mid-read: assert `ipReset` during RD_WAIT -> all outputs reach reset values asynchronously; no TX byte after release.

Source files
------------

// File: rtl/register_uart_bridge.sv
// UART byte-stream to register-block command bridge (read 0x01 ADDR, write 0x02 ADDR D0..D3).
// Optional inter-byte timeout is built when REGISTER_UART_BRIDGE_TIMEOUT_EN is defined.
module register_uart_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic        opError
);

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RSP_ERR   = 8'hEE;
  localparam logic [7:0] RSP_ACK   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RD_ADDR, S_RD_WAIT, S_RD_CAP, S_TX
  } state_t;

  // A zero timeout would expire on entry to ADDR, which is never intended.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic        error_q, error_d;

`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_valid_d = tx_valid_q;
    error_d    = 1'b0;
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ipRxValid) begin
          if (ipRxData == CMD_READ || ipRxData == CMD_WRITE) begin
            is_wr_d = (ipRxData == CMD_WRITE);
            state_d = S_ADDR;
          end else begin
            tx_shift_d = {24'h0, RSP_ERR};
            tx_cnt_d   = 3'd1;
            tx_valid_d = 1'b1;
            error_d    = 1'b1;
            state_d    = S_TX;
          end
        end
      end
      S_ADDR: begin
        if (ipRxValid) begin
          addr_d     = ipRxData;
          byte_cnt_d = 2'd0;
          state_d    = is_wr_q ? S_WDATA : S_RD_ADDR;
        end
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_WDATA: begin
        if (ipRxValid) begin
          wr_data_d[{byte_cnt_q, 3'b000} +: 8] = ipRxData;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d = 1'b1;
            state_d = S_WRITE;
          end
        end
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_WRITE: begin
        tx_shift_d = {24'h0, RSP_ACK};
        tx_cnt_d   = 3'd1;
        tx_valid_d = 1'b1;
        state_d    = S_TX;
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        tx_shift_d = ipRdData;
        tx_cnt_d   = 3'd4;
        tx_valid_d = 1'b1;
        state_d    = S_TX;
      end
      S_TX: begin
        if (tx_valid_q && ipTxReady) begin
          tx_shift_d = {8'h0, tx_shift_q[31:8]};
          tx_cnt_d   = tx_cnt_q - 3'd1;
          if (tx_cnt_q == 3'd1) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= 8'h0;
      wr_data_q  <= 32'h0;
      wr_en_q    <= 1'b0;
      tx_shift_q <= 32'h0;
      tx_cnt_q   <= 3'd0;
      tx_valid_q <= 1'b0;
      error_q    <= 1'b0;
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_valid_q <= tx_valid_d;
      error_q    <= error_d;
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign opTxData   = tx_shift_q[7:0];
  assign opTxValid  = tx_valid_q;
  assign opAddress  = addr_q;
  assign opWrData   = wr_data_q;
  assign opWrEnable = wr_en_q;
  assign opError    = error_q;

endmodule

// File: tb/tb_register_uart_bridge.sv
// Scoreboard bench for register_uart_bridge: directed packets, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_register_uart_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] rd_data;
  logic        opError;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int err_count = 0;
  int stall = 0;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  register_uart_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .ipClk(clk), .ipReset(rst),
    .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
    .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
    .ipRdData(rd_data), .opError(opError)
  );

  // Register block model: registered read data, one edge after the address is sampled.
  function automatic logic [31:0] reg_val(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hDEADBEEF;
      8'h02:   return 32'hCAFE0102;
      default: return {4{a}};
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) rd_data <= 32'h0;
    else     rd_data <= reg_val(opAddress);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", name, got, exp);
    end
  endtask

  // Monitor and TX-ready driver: compares outputs at negedge, drives ready after posedge.
  initial begin : monitor
    logic       hold_prev;
    logic [7:0] held;
    logic       wr_prev;
    logic       err_prev;
    logic [7:0] e;
    wr_t        w;
    hold_prev = 1'b0; held = 8'h0; wr_prev = 1'b0; err_prev = 1'b0;
    ipTxReady = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0; wr_prev = 1'b0; err_prev = 1'b0; stall = 0;
      end else begin
        if (hold_prev) begin
          checks++;
          if (!(opTxValid && opTxData == held)) begin
            errors++;
            $display("FAIL tx_hold got valid=%0b data=%02h exp valid=1 data=%02h", opTxValid, opTxData, held);
          end
        end
        if (opTxValid && ipTxReady) begin
          tx_count++;
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected got %02h exp none", opTxData);
          end else begin
            e = exp_tx.pop_front();
            if (opTxData !== e) begin
              errors++;
              $display("FAIL tx_byte got %02h exp %02h", opTxData, e);
            end
          end
          if (bp_mode) stall = 5;
        end
        hold_prev = opTxValid && !ipTxReady;
        held      = opTxData;
        if (opWrEnable) begin
          checks++;
          if (wr_prev) begin
            errors++;
            $display("FAIL wr_pulse_width got 2+ cycles exp 1");
          end else if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got a=%02h d=%08h exp none", opAddress, opWrData);
          end else begin
            w = exp_wr.pop_front();
            if (opAddress !== w.a || opWrData !== w.d) begin
              errors++;
              $display("FAIL wr_txn got a=%02h d=%08h exp a=%02h d=%08h", opAddress, opWrData, w.a, w.d);
            end
          end
        end
        wr_prev = opWrEnable;
        if (opError) begin
          err_count++;
          checks++;
          if (err_prev) begin
            errors++;
            $display("FAIL err_pulse_width got 2+ cycles exp 1");
          end
        end
        err_prev = opError;
      end
      @(posedge clk);
      #1;
      if (bp_mode && stall > 0) begin
        ipTxReady = 1'b0;
        stall--;
      end else begin
        ipTxReady = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(posedge clk); #1;
    ipRxValid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || opTxValid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_drain got tx_left=%0d wr_left=%0d exp 0 0", name, exp_tx.size(), exp_wr.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [31:0] v);
    exp_tx.push_back(v[7:0]);
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[23:16]);
    exp_tx.push_back(v[31:24]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(opAddress),  32'h0);
    chk({tag, "_wdata"}, opWrData,        32'h0);
    chk({tag, "_wen"},   32'(opWrEnable), 32'h0);
    chk({tag, "_txv"},   32'(opTxValid),  32'h0);
    chk({tag, "_txd"},   32'(opTxData),   32'h0);
    chk({tag, "_err"},   32'(opError),    32'h0);
  endtask

  initial begin : stim
    int e0;
    int t0;
    int n;
    rst = 1'b1; ipRxValid = 1'b0; ipRxData = 8'h0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write 0x12345678 to address 3, expect one strobe and ack A5.
    e0 = err_count;
    exp_wr.push_back('{a: 8'h03, d: 32'h12345678});
    exp_tx.push_back(8'hA5);
    send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    wait_done("write", 50);
    chk("write_hold_addr", 32'(opAddress), 32'h03);
    chk("write_hold_data", opWrData, 32'h12345678);

    // Read address 0.
    push_read(32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    wait_done("read", 50);

    // Same read under TX backpressure.
    t0 = tx_count;
    bp_mode = 1'b1;
    push_read(32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    wait_done("read_bp", 200);
    bp_mode = 1'b0;
    chk("read_bp_count", 32'(tx_count - t0), 32'd4);
    chk("no_err_so_far", 32'(err_count - e0), 32'd0);

    // Unknown command, then a normal read.
    e0 = err_count;
    exp_tx.push_back(8'hEE);
    send_byte(8'h7F);
    wait_done("unknown", 50);
    chk("unknown_err", 32'(err_count - e0), 32'd1);
    push_read(32'hCAFE0102);
    send_byte(8'h01); send_byte(8'h02);
    wait_done("read_after_err", 50);

    // A byte arriving while TX is busy is dropped.
    e0 = err_count;
    push_read(32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    n = 0;
    while (!opTxValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx_start_seen", 32'(opTxValid), 32'h1);
    send_byte(8'h7F);
    wait_done("drop_in_tx", 50);
    chk("drop_no_err", 32'(err_count - e0), 32'd0);

    // Stall mid-write for 30 idle cycles.
    e0 = err_count;
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h11);
    repeat (30) @(posedge clk);
    #1;
`ifdef REGISTER_UART_BRIDGE_TIMEOUT_EN
    chk("timeout_err", 32'(err_count - e0), 32'd1);
    push_read(32'hCAFE0102);
    send_byte(8'h01); send_byte(8'h02);
    wait_done("read_after_timeout", 50);
`else
    chk("no_timeout_err", 32'(err_count - e0), 32'd0);
    exp_wr.push_back('{a: 8'h05, d: 32'h44332211});
    exp_tx.push_back(8'hA5);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done("write_resume", 50);
`endif

    // Reset during RD_WAIT aborts the read.
    t0 = tx_count;
    send_byte(8'h01); send_byte(8'h02);
    chk("rd_addr_latched", 32'(opAddress), 32'h02);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    #3;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_tx", 32'(tx_count - t0), 32'd0);

    // Bridge is usable again after the abort.
    push_read(32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    wait_done("read_after_reset", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
